// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a valid/ready byte FIFO is drained back-to-back by a
// start/data/stop serializer onto uart_txd, LSB first.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int UART_BPS   = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int AW         = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tx_valid,
    input  logic [7:0]    tx_data,
    output logic          tx_ready,
    output logic [AW:0]   fifo_count,
    output logic          tx_busy,
    output logic          uart_txd
);

    localparam logic [15:0]   BPS_LAST = 16'(CLK_FREQ / UART_BPS - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;

    state_t        state_reg,   state_next;
    logic [15:0]   baud_reg,    baud_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic [7:0]    shift_reg,   shift_next;
    logic          txd_reg,     txd_next;
    logic          busy_reg,    busy_next;

    logic          push;
    logic          load;
    logic          bit_end;
    logic          fifo_nonempty;
    logic [2:0]    bit_idx_inc;

    assign tx_ready      = (count_reg != FULL_CNT);
    assign push          = tx_valid && tx_ready;
    assign fifo_nonempty = (count_reg != '0);
    assign bit_end       = (baud_reg == BPS_LAST);
    assign bit_idx_inc   = bit_idx_reg + 3'd1;

    assign fifo_count = count_reg;
    assign tx_busy    = busy_reg;
    assign uart_txd   = txd_reg;

    // Storage is not reset: discarding contents only needs the pointers and count cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= tx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (load) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({push, load})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            txd_reg     <= 1'b1;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            baud_reg    <= baud_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            txd_reg     <= txd_next;
            busy_reg    <= busy_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        baud_next    = bit_end ? 16'd0 : baud_reg + 16'd1;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        txd_next     = txd_reg;
        load         = 1'b0;

        case (state_reg)
            IDLE: begin
                baud_next = 16'd0;
                txd_next  = 1'b1;
                if (fifo_nonempty) begin
                    load       = 1'b1;
                    state_next = START;
                    txd_next   = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    bit_idx_next = 3'd0;
                    txd_next     = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                        txd_next   = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx_inc;
                        txd_next     = shift_reg[bit_idx_inc];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    // Chain straight into the next start bit when more bytes are waiting.
                    if (fifo_nonempty) begin
                        load       = 1'b1;
                        state_next = START;
                        txd_next   = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                txd_next   = 1'b1;
            end
        endcase

        if (load) begin
            shift_next = mem[rd_ptr_reg];
        end
        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: pushes queue expected bytes, a line monitor decodes
// frames at mid-bit and compares them in order, plus directed timing/reset checks.
module tb_uart_tx_fifo;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready;
    logic [AW:0]   fifo_count;
    logic          tx_busy;
    logic          uart_txd;

    int            checks = 0;
    int            passes = 0;
    int            cyc = 0;
    logic [7:0]    exp_q [$];
    int            starts_q [$];

    uart_tx_fifo #(
        .CLK_FREQ  (1000),
        .UART_BPS  (100),
        .FIFO_DEPTH(16),
        .AW        (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .fifo_count(fifo_count),
        .tx_busy   (tx_busy),
        .uart_txd  (uart_txd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            passes++;
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic send(input logic [7:0] d, input bit accepted);
        tx_valid = 1'b1;
        tx_data  = d;
        @(posedge clk);
        if (accepted) exp_q.push_back(d);
        #1;
    endtask

    task automatic idle_in();
        tx_valid = 1'b0;
        tx_data  = 8'h00;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int limit);
        bit done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && tx_busy === 1'b0) done = 1'b1;
        end
        check("drain_done", 32'(done), 32'd1);
    endtask

    // Line monitor: samples at mid-bit on the falling clock edge.
    initial begin
        bit         mact = 1'b0;
        int         mcnt = 0;
        logic [7:0] mbyte = 8'h00;
        logic [7:0] want;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                mact = 1'b0;
            end else if (!mact) begin
                if (uart_txd === 1'b0) begin
                    mact = 1'b1;
                    mcnt = 0;
                    starts_q.push_back(cyc);
                end
            end else begin
                mcnt++;
                if (mcnt == 5) begin
                    check("start_bit", 32'(uart_txd), 32'd0);
                end else if (mcnt >= 15 && mcnt <= 85 && (mcnt % 10) == 5) begin
                    mbyte[(mcnt - 15) / 10] = uart_txd;
                end else if (mcnt == 95) begin
                    check("stop_bit", 32'(uart_txd), 32'd1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 32'(mbyte), 32'hFFFF_FFFF);
                    end else begin
                        want = exp_q.pop_front();
                        check("frame_byte", 32'(mbyte), 32'(want));
                    end
                    mact = 1'b0;
                end
            end
        end
    end

    initial begin
        bit idle_ok;
        int exp_cnt;

        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        step(3);
        check("rst_txd",   32'(uart_txd),   32'd1);
        check("rst_ready", 32'(tx_ready),   32'd1);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_busy",  32'(tx_busy),    32'd0);
        rst = 1'b0;
        step(2);

        // 1: asynchronous reset mid-cycle while a frame is on the line
        send(8'h12, 1'b1);
        send(8'h34, 1'b1);
        idle_in();
        step(3);
        check("t1_pre_txd",   32'(uart_txd),   32'd0);
        check("t1_pre_busy",  32'(tx_busy),    32'd1);
        check("t1_pre_count", 32'(fifo_count), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t1_async_txd",   32'(uart_txd),   32'd1);
        check("t1_async_ready", 32'(tx_ready),   32'd1);
        check("t1_async_count", 32'(fifo_count), 32'd0);
        check("t1_async_busy",  32'(tx_busy),    32'd0);
        exp_q.delete();
        step(2);
        rst = 1'b0;
        step(3);

        // 2: single byte 0xA5, latency and frame timing
        send(8'hA5, 1'b1);
        idle_in();
        check("t2_count_after_push", 32'(fifo_count), 32'd1);
        check("t2_txd_after_push",   32'(uart_txd),   32'd1);
        step(1);
        check("t2_count_after_load", 32'(fifo_count), 32'd0);
        check("t2_txd_start",        32'(uart_txd),   32'd0);
        check("t2_busy_start",       32'(tx_busy),    32'd1);
        step(9);
        check("t2_txd_start_end",    32'(uart_txd),   32'd0);
        step(1);
        check("t2_txd_bit0",         32'(uart_txd),   32'd1);
        step(89);
        check("t2_busy_last",        32'(tx_busy),    32'd1);
        step(1);
        check("t2_busy_fall",        32'(tx_busy),    32'd0);
        check("t2_txd_idle",         32'(uart_txd),   32'd1);
        step(3);

        // 3: three back-to-back frames
        starts_q.delete();
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h55, 1'b1);
        idle_in();
        step(298);
        check("t3_busy_last", 32'(tx_busy), 32'd1);
        step(1);
        check("t3_busy_fall", 32'(tx_busy), 32'd0);
        check("t3_frames", 32'(starts_q.size()), 32'd3);
        if (starts_q.size() == 3) begin
            check("t3_gap01", 32'(starts_q[1] - starts_q[0]), 32'd100);
            check("t3_gap12", 32'(starts_q[2] - starts_q[1]), 32'd100);
        end
        step(3);

        // 4: hold valid for 20 cycles; 17 accepted (one popped at once), 3 refused while full
        for (int i = 0; i < 20; i++) begin
            send(8'(i), i <= 16);
            exp_cnt = (i == 0) ? 1 : ((i <= 16) ? i : 16);
            check("t4_count", 32'(fifo_count), 32'(exp_cnt));
            check("t4_ready", 32'(tx_ready),   32'(exp_cnt != 16));
        end
        idle_in();
        step(81);
        check("t4_ready_before_pop", 32'(tx_ready),   32'd0);
        step(1);
        check("t4_ready_after_pop",  32'(tx_ready),   32'd1);
        check("t4_count_after_pop",  32'(fifo_count), 32'd15);
        wait_drain(2000);
        step(3);

        // 5: push on the STOP->START load edge with three queued
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        send(8'h33, 1'b1);
        send(8'h44, 1'b1);
        idle_in();
        check("t5_count_pre", 32'(fifo_count), 32'd3);
        step(97);
        check("t5_count_before_edge", 32'(fifo_count), 32'd3);
        send(8'h5A, 1'b1);
        idle_in();
        check("t5_count_at_edge", 32'(fifo_count), 32'd3);
        check("t5_txd_restart",   32'(uart_txd),   32'd0);
        wait_drain(600);
        step(3);

        // 6: reset during data bit 3 of 0x3C with five queued
        send(8'h3C, 1'b1);
        send(8'h01, 1'b1);
        send(8'h02, 1'b1);
        send(8'h03, 1'b1);
        send(8'h04, 1'b1);
        send(8'h05, 1'b1);
        idle_in();
        step(40);
        check("t6_pre_bit3",  32'(uart_txd),   32'd1);
        check("t6_pre_busy",  32'(tx_busy),    32'd1);
        check("t6_pre_count", 32'(fifo_count), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_txd",   32'(uart_txd),   32'd1);
        check("t6_async_count", 32'(fifo_count), 32'd0);
        check("t6_async_busy",  32'(tx_busy),    32'd0);
        exp_q.delete();
        step(2);
        rst = 1'b0;
        idle_ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== '0) idle_ok = 1'b0;
        end
        check("t6_idle_after_reset", 32'(idle_ok), 32'd1);
        check("t6_no_pending", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered UART transmitter (8N1) for the CPU peripheral path.
- The core pushes bytes through a valid/ready handshake into an internal FIFO.
- An independent serializer drains the FIFO onto uart_txd, LSB first, with back-to-back frames and no idle gaps.
- Complements the serial receive path: software can queue a burst without polling per byte.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- UART_BPS, 115200, baud rate; BPS_CNT = CLK_FREQ/UART_BPS (integer divide) clocks per bit, must be >= 2.
- FIFO_DEPTH, 16, FIFO entries; power of two, >= 2.
- AW, 4, log2(FIFO_DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- tx_valid  input  1  core offers tx_data this cycle.
- tx_data  input  8  byte to queue.
- tx_ready  output  1  FIFO can accept a byte (count != FIFO_DEPTH).
- fifo_count  output  AW+1  number of queued bytes, 0..FIFO_DEPTH.
- tx_busy  output  1  serializer is not in IDLE.
- uart_txd  output  1  serial line, idles high.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high. All state is reset by rst asserting, independent of clk.
- Reset values: uart_txd=1, tx_busy=0, fifo_count=0, tx_ready=1, FSM=IDLE, FIFO pointers=0, baud counter=0, bit index=0.
- Push: occurs at a clk edge when tx_valid && tx_ready. tx_data is written at the write pointer, which then increments and wraps modulo FIFO_DEPTH.
- tx_ready: combinational from the registered count. tx_valid while full is ignored, with no data loss to stored entries.
- Pop: occurs only on a serializer load event, defined below. The read pointer increments and wraps.
- Push and pop on the same edge: count unchanged, both pointers advance. A full FIFO cannot push that cycle; ready rises the cycle after the pop.
- FSM states: IDLE, START, DATA, STOP. The baud counter runs 0..BPS_CNT-1; each bit lasts exactly BPS_CNT clocks.
- IDLE:
  - uart_txd=1.
  - If count>0 at an edge: load shift reg from FIFO head, pop, set uart_txd<=0, go to START, clear baud counter.
  - Latency: a push at edge N into an empty idle block drives uart_txd low after edge N+1.
- START: at baud counter = BPS_CNT-1, go to DATA, bit index=0, uart_txd<=shift[0].
- DATA:
  - At each bit end, advance the bit index and drive the next bit.
  - After bit 7 completes, go to STOP with uart_txd<=1.
- STOP: at bit end:
  - if count>0, load/pop, uart_txd<=0, go to START (no gap);
  - else go to IDLE.
- Frame length: exactly 10*BPS_CNT clocks from the falling start edge to the end of the stop bit.
- tx_busy: registered with the FSM, high for every state except IDLE.
- Data written after a load never alters the frame in flight; the shift register is a private copy.
- Reset mid-frame: uart_txd returns high immediately (async), the frame is truncated, and FIFO contents are discarded. After release, the block is idle until new pushes arrive.
- Widths: baud counter 16 bits. fifo_count saturates structurally at FIFO_DEPTH and never wraps to 0 when full.

Test Plan:
All scenarios use CLK_FREQ=1000, UART_BPS=100 (BPS_CNT=10), FIFO_DEPTH=16.
1. Assert rst mid-cycle with no clk edge -> uart_txd=1, tx_ready=1, fifo_count=0, tx_busy=0 immediately.
2. Push 0xA5 at edge N into idle block -> after edge N+1, txd=0 for 10 clks. Then bits 1,0,1,0,0,1,0,1 at 10 clks each, then stop high for 10 clks. tx_busy falls exactly 100 clks after the start edge. fifo_count goes 1 then 0.
3. Push 0x00, 0xFF, 0x55 on consecutive cycles -> three contiguous frames, 300 clks total. The stop bit of each frame is followed directly by the next start bit, and decoded bytes match in order.
4. Hold tx_valid high for 20 cycles with incrementing data 0x00..0x13 -> the first byte pops at once, and tx_ready drops when fifo_count reaches 16. After that, push/pop pairing keeps ready tied to pops, and all accepted bytes are serialized in order with none duplicated or lost.
5. With fifo_count=3 mid-stream, push on the exact edge of a STOP->START load -> fifo_count stays 3, and the new byte is transmitted last.
6. Assert rst during DATA bit 3 of 0x3C with 5 bytes queued -> uart_txd=1 immediately and fifo_count=0. After release and 200 idle clks, uart_txd stays 1 and tx_busy stays 0.
